// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a maskable interrupt line.
// Register window: CTRL (idx 0), PRESET (idx 1), COUNT (idx 2, read-only), reserved (idx 3).
module timer_irq_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        We,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic [31:0] w_count_next;
    logic        r_irq_flag;

    logic        w_sel;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic        w_auto;
    logic        w_en_clr;
    logic        w_irq_set;
    logic        w_unused_addr;

    assign w_sel         = (Addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr_ctrl     = We && w_sel && (Addr[3:2] == 2'd0);
    assign w_wr_preset   = We && w_sel && (Addr[3:2] == 2'd1);
    assign w_unused_addr = ^Addr[1:0];

    assign w_en   = r_ctrl[0];
    // MODE 1x behaves as one-shot, so only 01 selects auto-reload.
    assign w_auto = (r_ctrl[2:1] == 2'b01);

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_en_clr     = 1'b0;
        w_irq_set    = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_en) w_state_next = StLoad;
            end
            StLoad: begin
                // A disable that lands here aborts before loading so the count stays frozen.
                if (w_en) begin
                    w_count_next = r_preset;
                    w_state_next = StCnt;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StCnt: begin
                if (!w_en) begin
                    w_state_next = StIdle;
                end else if (r_count > 32'd1) begin
                    w_count_next = r_count - 32'd1;
                end else begin
                    w_count_next = '0;
                    w_state_next = StInt;
                end
            end
            StInt: begin
                w_irq_set = 1'b1;
                if (w_auto && w_en) begin
                    w_state_next = StLoad;
                end else begin
                    w_state_next = StIdle;
                    w_en_clr     = !w_auto;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;

            // A bus write to CTRL overrides the one-shot EN clear.
            if (w_wr_ctrl) begin
                r_ctrl <= WD[3:0];
            end else if (w_en_clr) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_wr_preset) r_preset <= WD;

            // Setting has priority so an expiry coinciding with a register write is not lost.
            if (w_irq_set) begin
                r_irq_flag <= 1'b1;
            end else if (w_wr_ctrl || w_wr_preset || w_auto) begin
                r_irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        RD = '0;
        case (Addr[3:2])
            2'd0:    RD = {28'd0, r_ctrl};
            2'd1:    RD = r_preset;
            2'd2:    RD = r_count;
            default: RD = '0;
        endcase
    end

    assign IRQ = r_irq_flag & r_ctrl[3];

endmodule
